// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single RegFile write port between the WB stage and a queued long-latency unit.
// Optional statistics counters are enabled by defining RF_ARB_STAT_EN.
module rf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_w_en,
  output logic [4:0]  rf_w_addr,
  output logic [31:0] rf_w_data,
  output logic [31:0] lu_pending
`ifdef RF_ARB_STAT_EN
  ,
  output logic [31:0] wb_stall_cnt,
  output logic [31:0] lu_full_cnt
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [4:0]        addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic        empty, full, push, pop, wait_expired;
  logic        fifo_grant, wb_grant;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [DEPTH-1:0] ent_valid;
  logic [31:0]      ent_mask [DEPTH];

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  generate
    if (MAX_WAIT == 0) begin : g_fifo_prio
      assign wait_expired = 1'b1;
    end else begin : g_wait_limit
      assign wait_expired = (wait_q >= WAIT_W'(MAX_WAIT));
    end
  endgenerate

  // An entry is live when its distance from the read pointer is below the occupancy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign ent_valid[gi] = ({1'b0, PTR_W'(gi) - rd_ptr_q} < count_q);
      assign ent_mask[gi]  = ent_valid[gi] ? (32'd1 << addr_mem[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    lu_pending = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      lu_pending = lu_pending | ent_mask[i];
    end
    lu_pending = reset ? 32'd0 : (lu_pending & ~32'd1);
  end

  always_comb begin
    lu_ready   = !reset && !full;
    push       = lu_valid && lu_ready;
    fifo_grant = !reset && !empty && (!wb_valid || wait_expired);
    wb_grant   = !reset && wb_valid && !fifo_grant;
    pop        = fifo_grant;
    wb_ready   = !reset && !fifo_grant;

    rf_w_en   = 1'b0;
    rf_w_addr = 5'd0;
    rf_w_data = 32'd0;
    if (fifo_grant) begin
      rf_w_en   = (head_addr != 5'd0);
      rf_w_addr = head_addr;
      rf_w_data = head_data;
    end else if (wb_grant) begin
      rf_w_en   = (wb_addr != 5'd0);
      rf_w_addr = wb_addr;
      rf_w_data = wb_data;
    end

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    wait_d = wait_q;
    if (fifo_grant || empty) begin
      wait_d = '0;
    end else if (wb_grant && (wait_q != '1)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= lu_addr;
      data_mem[wr_ptr_q] <= lu_data;
    end
  end

`ifdef RF_ARB_STAT_EN
  logic [31:0] wb_stall_q, lu_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_stall_q <= 32'd0;
      lu_full_q  <= 32'd0;
    end else begin
      if (wb_valid && !wb_ready) wb_stall_q <= wb_stall_q + 32'd1;
      if (lu_valid && !lu_ready) lu_full_q  <= lu_full_q + 32'd1;
    end
  end

  assign wb_stall_cnt = wb_stall_q;
  assign lu_full_cnt  = lu_full_q;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios followed by randomized traffic
// compared against a queue-based reference model.
module tb_rf_wport_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, lu_valid;
  logic [4:0]  wb_addr, lu_addr;
  logic [31:0] wb_data, lu_data;
  logic        wb_ready, lu_ready, rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data, lu_pending;
`ifdef RF_ARB_STAT_EN
  logic [31:0] wb_stall_cnt, lu_full_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .lu_pending(lu_pending)
`ifdef RF_ARB_STAT_EN
    , .wb_stall_cnt(wb_stall_cnt), .lu_full_cnt(lu_full_cnt)
`endif
  );

  // Reference model: the FIFO is a plain queue, the starvation wait a plain integer.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  int   mwait = 0;

  logic        exp_lu_ready, exp_wb_ready, exp_en, exp_fg, exp_grant;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data, exp_pend;

  function automatic void model_eval();
    exp_lu_ready = 1'b0; exp_wb_ready = 1'b0; exp_en = 1'b0; exp_fg = 1'b0;
    exp_grant = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_pend = 32'd0;
    if (!reset) begin
      exp_lu_ready = (mq.size() < DEPTH);
      exp_fg       = (mq.size() > 0) && (!wb_valid || mwait >= MAX_WAIT);
      exp_wb_ready = !exp_fg;
      exp_grant    = exp_fg || wb_valid;
      if (exp_fg) begin
        exp_addr = mq[0].a; exp_data = mq[0].d; exp_en = (mq[0].a != 5'd0);
      end else if (wb_valid) begin
        exp_addr = wb_addr; exp_data = wb_data; exp_en = (wb_addr != 5'd0);
      end
      foreach (mq[i]) if (mq[i].a != 5'd0) exp_pend[mq[i].a] = 1'b1;
    end
  endfunction

  task automatic tick();
    int   sz0;
    logic pushed;
    model_eval();
    $display("cyc %0d rst=%0b wb=%0b/%0d lu=%0b/%0d -> en=%0b addr=%0d data=%08h wbr=%0b lur=%0b pend=%08h",
             cyc, reset, wb_valid, wb_addr, lu_valid, lu_addr, rf_w_en, rf_w_addr, rf_w_data,
             wb_ready, lu_ready, lu_pending);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mwait = 0;
    end else begin
      sz0    = mq.size();
      pushed = lu_valid && exp_lu_ready;
      if (exp_fg) void'(mq.pop_front());
      if (pushed) mq.push_back('{a: lu_addr, d: lu_data});
      if (exp_fg || sz0 == 0) mwait = 0;
      else if (wb_valid && mwait < MAX_WAIT) mwait++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hAAAA5555;
    lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'h1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %0b want 0", rf_w_en); end
      n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL rst_wbr: got %0b want 0", wb_ready); end
      n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL rst_lur: got %0b want 0", lu_ready); end
      n_vec++; if (lu_pending !== 32'd0) begin n_err++; $display("FAIL rst_pend: got %08h want 0", lu_pending); end
      n_vec++; if ({rf_w_addr, rf_w_data} !== 37'd0) begin n_err++; $display("FAIL rst_ad: got %0d/%08h want 0/0", rf_w_addr, rf_w_data); end
      tick();
    end
    reset = 1'b0; wb_valid = 1'b0; lu_valid = 1'b0;
    #1;
    n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_lur: got %0b want 1", lu_ready); end
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_wbr: got %0b want 1", wb_ready); end
    n_vec++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL post_rst_en: got %0b want 0", rf_w_en); end
    tick();
  endtask

  task automatic test_wb_only();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; lu_valid = 1'b0;
    #1;
    n_vec++; if (rf_w_en !== 1'b1) begin n_err++; $display("FAIL wb_en: got %0b want 1", rf_w_en); end
    n_vec++; if (rf_w_addr !== 5'd5) begin n_err++; $display("FAIL wb_addr: got %0d want 5", rf_w_addr); end
    n_vec++; if (rf_w_data !== 32'h1234) begin n_err++; $display("FAIL wb_data: got %08h want 00001234", rf_w_data); end
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL wb_ready: got %0b want 1", wb_ready); end
    tick();
  endtask

  task automatic test_lu_idle();
    wb_valid = 1'b0; lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hDEAD;
    #1;
    n_vec++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL lu_bypass: got en=%0b want 0", rf_w_en); end
    n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL lu_accept: got %0b want 1", lu_ready); end
    tick();
    lu_valid = 1'b0;
    #1;
    n_vec++; if (lu_pending !== 32'h80) begin n_err++; $display("FAIL lu_pend7: got %08h want 00000080", lu_pending); end
    n_vec++; if (rf_w_en !== 1'b1 || rf_w_addr !== 5'd7) begin n_err++; $display("FAIL lu_write: got en=%0b addr=%0d want 1/7", rf_w_en, rf_w_addr); end
    n_vec++; if (rf_w_data !== 32'hDEAD) begin n_err++; $display("FAIL lu_data: got %08h want 0000dead", rf_w_data); end
    n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL lu_wbr: got %0b want 0", wb_ready); end
    tick();
    #1;
    n_vec++; if (lu_pending !== 32'd0) begin n_err++; $display("FAIL lu_pend_clr: got %08h want 0", lu_pending); end
    n_vec++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL lu_once: got en=%0b want 0", rf_w_en); end
    tick();
  endtask

  task automatic test_starvation();
    wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
    for (int c = 0; c < 7; c++) begin
      lu_valid = (c == 0); lu_addr = 5'd9; lu_data = 32'h99;
      #1;
      n_vec++;
      if (wb_ready !== (c != 5)) begin n_err++; $display("FAIL starve_wbr c%0d: got %0b want %0b", c, wb_ready, (c != 5)); end
      n_vec++;
      if (rf_w_addr !== ((c == 5) ? 5'd9 : 5'd2)) begin n_err++; $display("FAIL starve_addr c%0d: got %0d want %0d", c, rf_w_addr, (c == 5) ? 9 : 2); end
      tick();
    end
  endtask

  task automatic test_full();
    logic [4:0] got[$];
    bit done5 = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
    for (int c = 0; c < 24; c++) begin
      lu_addr  = (c == 0) ? 5'd3 : (c == 1) ? 5'd4 : 5'd5;
      lu_data  = {27'd0, lu_addr};
      lu_valid = !done5;
      #1;
      if (c <= 6) begin
        n_vec++;
        if (lu_ready !== !(c >= 2 && c <= 5)) begin n_err++; $display("FAIL full_lur c%0d: got %0b want %0b", c, lu_ready, !(c >= 2 && c <= 5)); end
      end
      if (!wb_ready) got.push_back(rf_w_addr);
      if (c >= 2 && lu_valid && lu_ready) done5 = 1'b1;
      tick();
    end
    n_vec++;
    if (got.size() != 3 || got[0] !== 5'd3 || got[1] !== 5'd4 || got[2] !== 5'd5) begin
      n_err++; $display("FAIL full_order: got %p want 3,4,5", got);
    end
  endtask

  task automatic test_r0();
    wb_valid = 1'b0; lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h55;
    #1;
    n_vec++; if (lu_pending !== 32'd0) begin n_err++; $display("FAIL r0_pend_a: got %08h want 0", lu_pending); end
    tick();
    lu_valid = 1'b0;
    #1;
    n_vec++; if (lu_pending !== 32'd0) begin n_err++; $display("FAIL r0_pend_b: got %08h want 0", lu_pending); end
    n_vec++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL r0_en: got %0b want 0", rf_w_en); end
    n_vec++; if (wb_ready !== 1'b0) begin n_err++; $display("FAIL r0_grant: got wbr=%0b want 0", wb_ready); end
    tick();
    #1;
    n_vec++; if (wb_ready !== 1'b1) begin n_err++; $display("FAIL r0_popped: got wbr=%0b want 1", wb_ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
    for (int c = 0; c < 2; c++) begin
      lu_valid = 1'b1; lu_addr = 5'(10 + c); lu_data = 32'(c);
      tick();
    end
    reset = 1'b1; lu_addr = 5'd12;
    #1;
    n_vec++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL mrst_en: got %0b want 0", rf_w_en); end
    n_vec++; if (wb_ready !== 1'b0 || lu_ready !== 1'b0) begin n_err++; $display("FAIL mrst_rdy: got %0b/%0b want 0/0", wb_ready, lu_ready); end
    tick();
    reset = 1'b0; wb_valid = 1'b0; lu_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (rf_w_en !== 1'b0) begin n_err++; $display("FAIL mrst_stale c%0d: got en=%0b addr=%0d want 0", c, rf_w_en, rf_w_addr); end
      n_vec++; if (lu_pending !== 32'd0) begin n_err++; $display("FAIL mrst_pend c%0d: got %08h want 0", c, lu_pending); end
      n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL mrst_lur c%0d: got %0b want 1", c, lu_ready); end
`ifdef RF_ARB_STAT_EN
      if (c == 0) begin
        n_vec++; if (wb_stall_cnt !== 32'd0 || lu_full_cnt !== 32'd0) begin n_err++; $display("FAIL mrst_stat: got %0d/%0d want 0/0", wb_stall_cnt, lu_full_cnt); end
      end
`endif
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      if (!(wb_valid && !wb_ready)) begin
        wb_valid = ($urandom_range(0, 9) < 7);
        wb_addr  = 5'($urandom);
        wb_data  = $urandom;
      end
      lu_valid = $urandom_range(0, 1) == 1;
      lu_addr  = 5'($urandom);
      lu_data  = $urandom;
      #1;
      model_eval();
      n_vec++; if (rf_w_en !== exp_en) begin n_err++; $display("FAIL rnd_en c%0d: got %0b want %0b", c, rf_w_en, exp_en); end
      n_vec++; if (wb_ready !== exp_wb_ready) begin n_err++; $display("FAIL rnd_wbr c%0d: got %0b want %0b", c, wb_ready, exp_wb_ready); end
      n_vec++; if (lu_ready !== exp_lu_ready) begin n_err++; $display("FAIL rnd_lur c%0d: got %0b want %0b", c, lu_ready, exp_lu_ready); end
      n_vec++; if (lu_pending !== exp_pend) begin n_err++; $display("FAIL rnd_pend c%0d: got %08h want %08h", c, lu_pending, exp_pend); end
      if (exp_en || !exp_grant) begin
        n_vec++;
        if (rf_w_addr !== exp_addr || rf_w_data !== exp_data) begin
          n_err++; $display("FAIL rnd_ad c%0d: got %0d/%08h want %0d/%08h", c, rf_w_addr, rf_w_data, exp_addr, exp_data);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    @(negedge clk);
    test_reset();
    test_wb_only();
    test_lu_idle();
    test_starvation();
    test_full();
    test_r0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
